// File: rtl/interrupt_request_register_sync.sv
// Interrupt request register: per-channel synchroniser, edge/level detection,
// pending hold, output freeze and sticky edge-overrun flags.

module irr_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  input  logic level_mode,
  input  logic clear,
  input  logic freeze,
  output logic irr_next,
  output logic irr,
  output logic overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, pend_q, mode_q, irr_q, ovr_q;
  logic pend_d, irr_d, ovr_d;
  logic sync, edge_ev, kill;

  always_comb begin
    sync    = sync_q[SYNC_STAGES-1];
    edge_ev = sync & ~prev_q;
    // A mode change behaves like a clear so stale state never crosses modes.
    kill    = clear | (level_mode ^ mode_q);
    pend_d  = 1'b0;
    ovr_d   = ovr_q;
    irr_d   = irr_q;
    if (kill) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
      irr_d  = 1'b0;
    end else begin
      if (level_mode) begin
        pend_d = sync;
      end else begin
        pend_d = pend_q | edge_ev;
        if (edge_ev && pend_q) ovr_d = 1'b1;
      end
      if (!freeze) irr_d = pend_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      mode_q <= 1'b0;
      irr_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync;
      pend_q <= pend_d;
      mode_q <= level_mode;
      irr_q  <= irr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign irr_next = irr_d;
  assign irr      = irr_q;
  assign overrun  = ovr_q;

endmodule

module interrupt_request_register_sync #(
  parameter int NUM_IR      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] ir_req_pin,
  input  logic [NUM_IR-1:0] level_mode,
  input  logic [NUM_IR-1:0] clear_ir_line,
  input  logic              freeze_irr,
  output logic [NUM_IR-1:0] interrupt_req_reg,
  output logic              pending_any,
  output logic [NUM_IR-1:0] edge_overrun
);

  logic [NUM_IR-1:0] irr_next;
  logic              pend_any_q;

  for (genvar i = 0; i < NUM_IR; i++) begin : g_lane
    irr_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .pin        (ir_req_pin[i]),
      .level_mode (level_mode[i]),
      .clear      (clear_ir_line[i]),
      .freeze     (freeze_irr),
      .irr_next   (irr_next[i]),
      .irr        (interrupt_req_reg[i]),
      .overrun    (edge_overrun[i])
    );
  end

  // Built from the next output value so it lines up with interrupt_req_reg.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pend_any_q <= 1'b0;
    else          pend_any_q <= |irr_next;
  end

  assign pending_any = pend_any_q;

endmodule

// File: tb/tb_interrupt_request_register_sync.sv
// Directed scoreboard bench: stimulus queues expected outputs tagged with the
// clock edge after which they must hold; a negedge monitor pops and compares.

module tb_interrupt_request_register_sync;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] ir_req_pin, level_mode, clear_ir_line;
  logic       freeze_irr;
  logic [7:0] interrupt_req_reg, edge_overrun;
  logic       pending_any;

  interrupt_request_register_sync #(.NUM_IR(8), .SYNC_STAGES(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ir_req_pin        (ir_req_pin),
    .level_mode        (level_mode),
    .clear_ir_line     (clear_ir_line),
    .freeze_irr        (freeze_irr),
    .interrupt_req_reg (interrupt_req_reg),
    .pending_any       (pending_any),
    .edge_overrun      (edge_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned at;
    logic [7:0]  irr;
    logic [7:0]  ovr;
    logic        pa;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.at != cyc) begin
        failures++;
        $display("FAIL stale_entry edge=%0d seen_at=%0d", e.at, cyc);
      end else if (interrupt_req_reg !== e.irr || edge_overrun !== e.ovr ||
                   pending_any !== e.pa) begin
        failures++;
        $display("FAIL edge%0d got irr=%h ovr=%h pa=%b expected irr=%h ovr=%h pa=%b",
                 cyc, interrupt_req_reg, edge_overrun, pending_any, e.irr, e.ovr, e.pa);
      end
    end
  end

  task automatic expect_at(input int unsigned at, input logic [7:0] irr,
                           input logic [7:0] ovr, input logic pa);
    exp_t x;
    x.at = at; x.irr = irr; x.ovr = ovr; x.pa = pa;
    sb.push_back(x);
  endtask

  // Advance to just after edge n (inputs driven here are first sampled at n+1).
  task automatic wait_to(input int unsigned n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ir_req_pin = '0; level_mode = '0;
    clear_ir_line = '0; freeze_irr = 1'b0;
    expect_at(1, 8'h00, 8'h00, 1'b0);
    wait_to(2);
    reset_n = 1'b1;
    expect_at(3, 8'h00, 8'h00, 1'b0);

    // Edge detect on channel 3, then clear
    wait_to(10); ir_req_pin[3] = 1'b1;
    expect_at(12, 8'h00, 8'h00, 1'b0);
    expect_at(13, 8'h08, 8'h00, 1'b1);
    wait_to(14); ir_req_pin[3] = 1'b0;
    expect_at(16, 8'h08, 8'h00, 1'b1);
    wait_to(19); clear_ir_line[3] = 1'b1;
    expect_at(20, 8'h00, 8'h00, 1'b0);
    wait_to(20); clear_ir_line[3] = 1'b0;
    expect_at(23, 8'h00, 8'h00, 1'b0);

    // Level mode on channel 5
    wait_to(25); level_mode = 8'hFF;
    wait_to(30); ir_req_pin[5] = 1'b1;
    expect_at(32, 8'h00, 8'h00, 1'b0);
    expect_at(33, 8'h20, 8'h00, 1'b1);
    wait_to(35); clear_ir_line[5] = 1'b1;
    expect_at(36, 8'h00, 8'h00, 1'b0);
    wait_to(36); clear_ir_line[5] = 1'b0;
    expect_at(37, 8'h20, 8'h00, 1'b1);
    wait_to(40); ir_req_pin[5] = 1'b0;
    expect_at(42, 8'h20, 8'h00, 1'b1);
    expect_at(43, 8'h00, 8'h00, 1'b0);

    // Freeze holds output; pending edge appears at release
    wait_to(45); level_mode = 8'h00;
    wait_to(47); freeze_irr = 1'b1;
    wait_to(48); ir_req_pin[0] = 1'b1;
    expect_at(51, 8'h00, 8'h00, 1'b0);
    expect_at(53, 8'h00, 8'h00, 1'b0);
    wait_to(54); freeze_irr = 1'b0;
    expect_at(54, 8'h00, 8'h00, 1'b0);
    expect_at(55, 8'h01, 8'h00, 1'b1);
    wait_to(56); ir_req_pin[0] = 1'b0; clear_ir_line[0] = 1'b1;
    expect_at(57, 8'h00, 8'h00, 1'b0);
    wait_to(57); clear_ir_line[0] = 1'b0;

    // Overrun on channel 7
    wait_to(60); ir_req_pin[7] = 1'b1;
    expect_at(63, 8'h80, 8'h00, 1'b1);
    wait_to(63); ir_req_pin[7] = 1'b0;
    wait_to(66); ir_req_pin[7] = 1'b1;
    expect_at(68, 8'h80, 8'h00, 1'b1);
    expect_at(69, 8'h80, 8'h80, 1'b1);
    wait_to(69); ir_req_pin[7] = 1'b0;
    wait_to(72); clear_ir_line[7] = 1'b1;
    expect_at(73, 8'h00, 8'h00, 1'b0);
    wait_to(73); clear_ir_line[7] = 1'b0;

    // Clear collides with edge event on channel 2; held-high line must not retrigger
    wait_to(76); ir_req_pin[2] = 1'b1;
    wait_to(78); clear_ir_line[2] = 1'b1;
    expect_at(79, 8'h00, 8'h00, 1'b0);
    wait_to(79); clear_ir_line[2] = 1'b0;
    expect_at(83, 8'h00, 8'h00, 1'b0);
    expect_at(90, 8'h00, 8'h00, 1'b0);
    wait_to(90); ir_req_pin[2] = 1'b0;
    wait_to(94); ir_req_pin[2] = 1'b1;
    expect_at(96, 8'h00, 8'h00, 1'b0);
    expect_at(97, 8'h04, 8'h00, 1'b1);

    // Asynchronous reset mid-request, lines high at release
    wait_to(98); ir_req_pin[6] = 1'b1;
    wait_to(99); reset_n = 1'b0;
    expect_at(99, 8'h00, 8'h00, 1'b0);
    expect_at(100, 8'h00, 8'h00, 1'b0);
    wait_to(101); reset_n = 1'b1;
    expect_at(103, 8'h00, 8'h00, 1'b0);
    expect_at(104, 8'h44, 8'h00, 1'b1);

    // Mode switch on pending channel 1 clears it on that edge
    wait_to(105); ir_req_pin[1] = 1'b1;
    expect_at(108, 8'h46, 8'h00, 1'b1);
    wait_to(110); level_mode[1] = 1'b1;
    expect_at(110, 8'h46, 8'h00, 1'b1);
    expect_at(111, 8'h44, 8'h00, 1'b1);
    expect_at(112, 8'h46, 8'h00, 1'b1);

    wait_to(115);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL unchecked_entries left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
